// File: rtl/adaptive_phase_controller.sv
// Adaptive traffic-signal phase controller.
// Serves one phase at a time through GREEN -> YELLOW -> ALL_RED. The next
// phase is chosen round-robin among phases with waiting vehicles, and a valid
// emergency request always wins the selection. Sensors are double-flopped
// before use. Every output is a flop, so lights never glitch.
module adaptive_phase_controller #(
    parameter int NUM_PHASES   = 4,
    parameter int TICK_DIV     = 50000000,
    parameter int MIN_GREEN    = 5,
    parameter int MAX_GREEN    = 20,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    localparam int PH_W        = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PHASES-1:0]   demand,
    input  logic [NUM_PHASES-1:0]   congest,
    input  logic                    emerg_req,
    input  logic [PH_W-1:0]         emerg_phase,
    output logic [2*NUM_PHASES-1:0] lights,
    output logic [PH_W-1:0]         active_phase,
    output logic [1:0]              state,
    output logic                    green_start
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GREEN   = 2'b01,
        ST_YELLOW  = 2'b10,
        ST_ALL_RED = 2'b11
    } ctrl_state_e;

    localparam int              PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [7:0]      MIN_G      = 8'(MIN_GREEN);
    localparam logic [7:0]      MAX_G      = 8'(MAX_GREEN);
    localparam logic [7:0]      YEL_T      = 8'(YELLOW_TIME);
    localparam logic [7:0]      AR_T       = 8'(ALL_RED_TIME);

    // Round-robin pick: emergency first, else first demanding phase after cur.
    function automatic logic [PH_W-1:0] next_phase_f(
        input logic [PH_W-1:0]       cur,
        input logic [NUM_PHASES-1:0] dem,
        input logic                  emg_valid,
        input logic [PH_W-1:0]       emg_ph
    );
        logic [PH_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = cur;
        found = 1'b0;
        if (emg_valid) begin
            pick = emg_ph;
        end else begin
            for (int k = 1; k <= NUM_PHASES; k++) begin
                idx = (int'(cur) + k) % NUM_PHASES;
                if (!found && dem[idx]) begin
                    pick  = PH_W'(idx);
                    found = 1'b1;
                end else begin
                    pick = pick;
                end
            end
        end
        return pick;
    endfunction

    // Lamp encoding: only the served phase can be non-red.
    function automatic logic [2*NUM_PHASES-1:0] lights_f(
        input ctrl_state_e     st,
        input logic [PH_W-1:0] ph
    );
        logic [2*NUM_PHASES-1:0] l;
        l = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (PH_W'(i) == ph) begin
                case (st)
                    ST_GREEN:  l[2*i +: 2] = 2'b10;
                    ST_YELLOW: l[2*i +: 2] = 2'b01;
                    default:   l[2*i +: 2] = 2'b00;
                endcase
            end else begin
                l[2*i +: 2] = 2'b00;
            end
        end
        return l;
    endfunction

    logic [NUM_PHASES-1:0]   demand_meta_r, demand_sync_r;
    logic [NUM_PHASES-1:0]   congest_meta_r, congest_sync_r;
    logic                    emerg_req_meta_r, emerg_req_sync_r;
    logic [PH_W-1:0]         emerg_phase_meta_r, emerg_phase_sync_r;
    logic [PRESC_W-1:0]      presc_r;
    logic [7:0]              timer_r;
    ctrl_state_e             state_r, state_nxt_s;
    logic [PH_W-1:0]         phase_r, phase_nxt_s;
    logic [2*NUM_PHASES-1:0] lights_r;
    logic                    green_start_r;

    logic                    tick_s;
    logic [7:0]              g_s;
    logic                    emerg_valid_s;
    logic [NUM_PHASES-1:0]   phase_mask_s;
    logic                    other_dem_s;
    logic                    congest_act_s;
    logic                    any_req_s;
    logic [PH_W-1:0]         sel_phase_s;

    // Two-flop synchronisers for all asynchronous sensor inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            demand_meta_r      <= '0;
            demand_sync_r      <= '0;
            congest_meta_r     <= '0;
            congest_sync_r     <= '0;
            emerg_req_meta_r   <= 1'b0;
            emerg_req_sync_r   <= 1'b0;
            emerg_phase_meta_r <= '0;
            emerg_phase_sync_r <= '0;
        end else begin
            demand_meta_r      <= demand;
            demand_sync_r      <= demand_meta_r;
            congest_meta_r     <= congest;
            congest_sync_r     <= congest_meta_r;
            emerg_req_meta_r   <= emerg_req;
            emerg_req_sync_r   <= emerg_req_meta_r;
            emerg_phase_meta_r <= emerg_phase;
            emerg_phase_sync_r <= emerg_phase_meta_r;
        end
    end

    assign tick_s = (presc_r == PRESC_LAST);

    // Free-running prescaler producing the one-cycle timing tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PRESC_W'(1);
        end
    end

    // Decision helpers derived from the synchronised sensors.
    always_comb begin
        g_s           = (timer_r == 8'hFF) ? 8'hFF : (timer_r + 8'd1);
        emerg_valid_s = emerg_req_sync_r &&
                        ({{(32-PH_W){1'b0}}, emerg_phase_sync_r} < 32'(NUM_PHASES));
        phase_mask_s  = {{(NUM_PHASES-1){1'b0}}, 1'b1} << phase_r;
        other_dem_s   = |(demand_sync_r & ~phase_mask_s);
        congest_act_s = |(congest_sync_r & phase_mask_s);
        any_req_s     = (|demand_sync_r) || emerg_valid_s;
        sel_phase_s   = next_phase_f(phase_r, demand_sync_r, emerg_valid_s, emerg_phase_sync_r);
    end

    // Next-state and next-phase logic.
    always_comb begin
        state_nxt_s = state_r;
        phase_nxt_s = phase_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_GREEN;
                    phase_nxt_s = sel_phase_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GREEN: begin
                if (!tick_s) begin
                    state_nxt_s = ST_GREEN;
                end else if (emerg_valid_s && (emerg_phase_sync_r == phase_r)) begin
                    // Preempted phase already being served: hold it.
                    state_nxt_s = ST_GREEN;
                end else if (emerg_valid_s ||
                             ((g_s >= MIN_G) && other_dem_s && !congest_act_s) ||
                             ((g_s >= MAX_G) && other_dem_s)) begin
                    state_nxt_s = ST_YELLOW;
                end else begin
                    state_nxt_s = ST_GREEN;
                end
            end
            ST_YELLOW: begin
                if (tick_s && (g_s == YEL_T)) begin
                    state_nxt_s = ST_ALL_RED;
                end else begin
                    state_nxt_s = ST_YELLOW;
                end
            end
            ST_ALL_RED: begin
                if (tick_s && (g_s == AR_T)) begin
                    if (any_req_s) begin
                        state_nxt_s = ST_GREEN;
                        phase_nxt_s = sel_phase_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_ALL_RED;
                end
            end
            default: begin
                state_nxt_s = ST_ALL_RED;
            end
        endcase
    end

    // Phase timer: cleared on every state entry, saturating tick counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_r <= 8'd0;
        end else if (state_nxt_s != state_r) begin
            timer_r <= 8'd0;
        end else if (tick_s) begin
            timer_r <= g_s;
        end else begin
            timer_r <= timer_r;
        end
    end

    // State, phase and registered outputs; lights follow the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_ALL_RED;
            phase_r       <= PH_W'(NUM_PHASES - 1);
            lights_r      <= '0;
            green_start_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            phase_r       <= phase_nxt_s;
            lights_r      <= lights_f(state_nxt_s, phase_nxt_s);
            green_start_r <= (state_nxt_s == ST_GREEN) && (state_r != ST_GREEN);
        end
    end

    assign lights       = lights_r;
    assign active_phase = phase_r;
    assign state        = state_r;
    assign green_start  = green_start_r;

endmodule
